// File: rtl/gci_std_kmc_scancode_decoder.sv
// Set-2 scancode decoder: folds E0/F0 prefixes into one key event per keystroke,
// splits out device status bytes and abandons stale prefixes after a timeout.
// Optional macro GCI_STD_KMC_E1_PAUSE_EN collapses the 8-byte Pause sequence into one event.
// Ports:
//   iCLOCK, inRESET (async, active-low), iCLEAR (sync clear)
//   iRX_REQ/iRX_DATA        : byte strobe and byte from the PS2 receiver
//   oKEY_VALID/oKEY_DATA    : {break, extended, code}, held until !iKEY_BUSY
//   oSTAT_REQ/oSTAT_DATA    : 1-cycle strobe for device status bytes
//   oERR                    : 1-cycle strobe on timeout, bad sequence or overrun
module gci_std_kmc_scancode_decoder #(
    parameter int                   TIMEOUT_N = 17,
    parameter logic [TIMEOUT_N-1:0] TIMEOUT   = 17'd100000
) (
    input  logic       iCLOCK,
    input  logic       inRESET,
    input  logic       iCLEAR,
    input  logic       iRX_REQ,
    input  logic [7:0] iRX_DATA,
    output logic       oKEY_VALID,
    input  logic       iKEY_BUSY,
    output logic [9:0] oKEY_DATA,
    output logic       oSTAT_REQ,
    output logic [7:0] oSTAT_DATA,
    output logic       oERR
);

    localparam logic [TIMEOUT_N-1:0] L_ONE  = {{(TIMEOUT_N-1){1'b0}}, 1'b1};
    localparam logic [TIMEOUT_N-1:0] L_TERM = TIMEOUT - L_ONE;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
`ifdef GCI_STD_KMC_E1_PAUSE_EN
        ST_EXT_BRK,
        ST_PAUSE
`else
        ST_EXT_BRK
`endif
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nx;
    logic [TIMEOUT_N-1:0]   r_tcnt;
    logic                   r_key_valid;
    logic [9:0]             r_key_data;
    logic                   r_stat_req;
    logic [7:0]             r_stat_data;
    logic                   r_err;

    logic                   w_is_stat;
    logic                   w_emit;
    logic [9:0]             w_emit_data;
    logic                   w_seq_err;
    logic                   w_stat;
    logic                   w_timeout;
    logic                   w_accept;
    logic                   w_overrun;

`ifdef GCI_STD_KMC_E1_PAUSE_EN
    logic [2:0]             r_pcnt;
    logic [2:0]             w_pcnt_nx;
`endif

    assign w_is_stat = iRX_DATA inside {8'hAA, 8'hFA, 8'hFC, 8'hFD,
                                        8'hFE, 8'hEE, 8'h00, 8'hFF};

    assign w_accept  = r_key_valid && !iKEY_BUSY;
    // A new event can only be loaded if the slot is free or empties this cycle.
    assign w_overrun = w_emit && r_key_valid && !w_accept;

    always_comb begin
        w_state_nx  = r_state;
        w_emit      = 1'b0;
        w_emit_data = 10'h000;
        w_seq_err   = 1'b0;
        w_stat      = 1'b0;
        w_timeout   = 1'b0;
`ifdef GCI_STD_KMC_E1_PAUSE_EN
        w_pcnt_nx   = r_pcnt;
`endif
        if (iRX_REQ) begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_is_stat) begin
                        w_stat = 1'b1;
                    end else if (iRX_DATA == 8'hE0) begin
                        w_state_nx = ST_EXT;
                    end else if (iRX_DATA == 8'hF0) begin
                        w_state_nx = ST_BRK;
                    end else if (iRX_DATA == 8'hE1) begin
`ifdef GCI_STD_KMC_E1_PAUSE_EN
                        w_state_nx = ST_PAUSE;
                        w_pcnt_nx  = 3'd0;
`endif
                    end else begin
                        w_emit      = 1'b1;
                        w_emit_data = {2'b00, iRX_DATA};
                    end
                end
                ST_EXT: begin
                    if (w_is_stat) begin
                        w_seq_err  = 1'b1;
                        w_state_nx = ST_IDLE;
                    end else if (iRX_DATA == 8'hF0) begin
                        w_state_nx = ST_EXT_BRK;
                    end else if (iRX_DATA != 8'hE0) begin
                        w_emit      = 1'b1;
                        w_emit_data = {2'b01, iRX_DATA};
                        w_state_nx  = ST_IDLE;
                    end
                end
                ST_BRK: begin
                    if (w_is_stat) begin
                        w_seq_err  = 1'b1;
                        w_state_nx = ST_IDLE;
                    end else if (iRX_DATA == 8'hE0) begin
                        // E0 after F0 is out of order; restart as an extended prefix.
                        w_seq_err  = 1'b1;
                        w_state_nx = ST_EXT;
                    end else if (iRX_DATA != 8'hF0) begin
                        w_emit      = 1'b1;
                        w_emit_data = {2'b10, iRX_DATA};
                        w_state_nx  = ST_IDLE;
                    end
                end
                ST_EXT_BRK: begin
                    if (w_is_stat || iRX_DATA == 8'hE0 || iRX_DATA == 8'hF0) begin
                        w_seq_err  = 1'b1;
                        w_state_nx = ST_IDLE;
                    end else begin
                        w_emit      = 1'b1;
                        w_emit_data = {2'b11, iRX_DATA};
                        w_state_nx  = ST_IDLE;
                    end
                end
`ifdef GCI_STD_KMC_E1_PAUSE_EN
                ST_PAUSE: begin
                    // Bytes are swallowed blind; the 7th closes the sequence.
                    if (r_pcnt == 3'd6) begin
                        w_emit      = 1'b1;
                        w_emit_data = {2'b01, 8'hE1};
                        w_state_nx  = ST_IDLE;
                    end else begin
                        w_pcnt_nx = r_pcnt + 3'd1;
                    end
                end
`endif
                default: begin
                    w_state_nx = ST_IDLE;
                end
            endcase
        end else if (r_state != ST_IDLE && r_tcnt == L_TERM) begin
            // Counter would reach TIMEOUT on this edge.
            w_timeout  = 1'b1;
            w_state_nx = ST_IDLE;
        end
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            r_state <= ST_IDLE;
            r_tcnt  <= '0;
        end else if (iCLEAR) begin
            r_state <= ST_IDLE;
            r_tcnt  <= '0;
        end else begin
            r_state <= w_state_nx;
            if (iRX_REQ || w_timeout || r_state == ST_IDLE) begin
                r_tcnt <= '0;
            end else begin
                r_tcnt <= r_tcnt + L_ONE;
            end
        end
    end

`ifdef GCI_STD_KMC_E1_PAUSE_EN
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            r_pcnt <= 3'd0;
        end else if (iCLEAR) begin
            r_pcnt <= 3'd0;
        end else begin
            r_pcnt <= w_pcnt_nx;
        end
    end
`endif

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            r_key_valid <= 1'b0;
            r_key_data  <= 10'h000;
            r_stat_req  <= 1'b0;
            r_stat_data <= 8'h00;
            r_err       <= 1'b0;
        end else if (iCLEAR) begin
            r_key_valid <= 1'b0;
            r_stat_req  <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            if (w_emit && (!r_key_valid || w_accept)) begin
                r_key_valid <= 1'b1;
                r_key_data  <= w_emit_data;
            end else if (w_accept) begin
                r_key_valid <= 1'b0;
            end
            r_stat_req <= w_stat;
            if (w_stat) begin
                r_stat_data <= iRX_DATA;
            end
            r_err <= w_seq_err || w_timeout || w_overrun;
        end
    end

    assign oKEY_VALID = r_key_valid;
    assign oKEY_DATA  = r_key_data;
    assign oSTAT_REQ  = r_stat_req;
    assign oSTAT_DATA = r_stat_data;
    assign oERR       = r_err;

endmodule
